sha3_block_sequencer: RTL and testbench
=======================================

SHA3_BLOCK_SEQUENCER -- requirements
Module: sha3_block_sequencer

Interface
REQ-001 The module SHALL have port clk, input, 1 bit: single rising-edge clock for all state.
REQ-002 The module SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-003 The module SHALL have port s_data, input, 64 bits: message word; byte 0 is on s_data[63:56].
REQ-004 The module SHALL have port s_valid, input, 1 bit: s_data, s_last and s_bytes are valid.
REQ-005 The module SHALL have port s_ready, output, 1 bit: the sequencer accepts a word when s_valid and s_ready are both 1.
REQ-006 The module SHALL have port s_last, input, 1 bit: final word of the message.
REQ-007 The module SHALL have port s_bytes, input, 4 bits: valid bytes in the last word (0..8); values above 8 are treated as 8; ignored when s_last is 0.
REQ-008 The module SHALL have port core_in, output, 1088 bits: rate block to the SHA3 core; block byte i is on bits [1087-8i -: 8].
REQ-009 The module SHALL have port core_in_valid, output, 1 bit: one-cycle block strobe to the core.
REQ-010 The module SHALL have port core_more, output, 1 bit: 1 means more blocks follow; held stable from the strobe until the next strobe.
REQ-011 The module SHALL have port core_hash_next, input, 1 bit: core ready for the next block of the same message.
REQ-012 The module SHALL have ports core_out, input, 256 bits, and core_out_valid, input, 1 bit: digest from the core.
REQ-013 The module SHALL have port digest, output, 256 bits, and digest_valid, output, 1 bit: captured digest.
REQ-014 The module SHALL have port digest_ready, input, 1 bit: consumer accepts the digest.

Function
REQ-015 The block buffer SHALL be 17 x 64-bit words, with word k at core_in[1087-64k -: 64], plus a 5-bit word counter (0..16).
REQ-016 The state machine SHALL have the states FILL, ISSUE, WAIT_NEXT, WAIT_OUT and DONE; s_ready SHALL be 1 only in FILL.
REQ-017 FILL: each accepted word SHALL be written to word[cnt], after which cnt increments.
REQ-018 FILL, non-last word with cnt=16: the sequencer SHALL go to ISSUE with core_more=1.
REQ-019 FILL, last word: let p = 8*cnt + min(s_bytes,8). Bytes at positions p and above in that word SHALL be zeroed.
REQ-020 If p<135, byte p SHALL be set to 0x06 and byte 135 to 0x80. If p=135, byte 135 SHALL be 0x86. In both cases the sequencer goes to ISSUE with core_more=0.
REQ-021 If p=136, the sequencer SHALL set pad_pending=1 and go to ISSUE with core_more=1.
REQ-022 ISSUE SHALL last exactly 1 cycle: core_in_valid=1 and core_in=buffer. The strobe SHALL come in the cycle after the word that completes the block is accepted.
REQ-023 On leaving ISSUE, the sequencer SHALL go to WAIT_NEXT if core_more=1, else to WAIT_OUT.
REQ-024 On leaving ISSUE, the buffer and cnt SHALL clear to 0; core_in SHALL read 0 outside ISSUE.
REQ-025 WAIT_NEXT, on core_hash_next=1 with pad_pending=1: the buffer SHALL be loaded with byte0=0x06, byte135=0x80 and all other bytes 0. pad_pending SHALL clear, core_more SHALL be set to 0, and the sequencer goes to ISSUE.
REQ-026 WAIT_NEXT, on core_hash_next=1 with pad_pending=0: the sequencer SHALL go to FILL.
REQ-027 WAIT_OUT, on core_out_valid=1: the sequencer SHALL capture core_out into digest, set digest_valid=1 and go to DONE.
REQ-028 DONE: digest and digest_valid SHALL hold until digest_ready=1. In that cycle digest_valid clears and the next state is FILL.
REQ-029 core_hash_next and core_out_valid SHALL be ignored in all states other than WAIT_NEXT and WAIT_OUT respectively.
REQ-030 core_in_valid SHALL never assert twice without an intervening core_hash_next or core_out_valid.

Reset
REQ-031 While rst_n=0, state SHALL be FILL and cnt, buffer, pad_pending, core_in_valid, core_more, digest_valid and digest SHALL all be 0; s_ready SHALL be 1 from the first clock after release.
REQ-032 Reset asserted mid-message or mid-core-wait SHALL abandon the message; no core_in_valid or digest_valid SHALL follow from it.

Verification
REQ-033 Empty message: word0 with s_last=1, s_bytes=0 -> one strobe, core_more=0, byte0=0x06, byte135=0x80, rest 0; core_out_valid with 0xA7FF..(256b) -> digest equals it, digest_valid=1.
REQ-034 3-word message, s_bytes=3 on word 2 -> byte 19=0x06, bytes 20..134=0, byte135=0x80, a single strobe.
REQ-035 135-byte message (17 words, last s_bytes=7) -> single block with byte135=0x86, core_more=0.
REQ-036 136-byte message -> strobe 1 with core_more=1 and the data unchanged; after core_hash_next, strobe 2 is the pad-only block with core_more=0.
REQ-037 Two-block message with core_hash_next delayed 48 cycles and digest_ready held low 5 cycles -> s_ready=0 throughout the wait; digest stable for 5 cycles, then digest_valid drops.
REQ-038 rst_n pulsed low during WAIT_NEXT -> all outputs 0; a subsequent new message produces correct padding with cnt starting at 0.

Source files
------------

// File: rtl/sha3_block_sequencer_if.sv
// Message-word stream, SHA3 core block/digest handshake and digest output bundle.
// The sequencer takes the slave view; the stream source, core and digest consumer take the master view.
interface sha3_block_sequencer_if;
  logic [63:0]   s_data;
  logic          s_valid;
  logic          s_ready;
  logic          s_last;
  logic [3:0]    s_bytes;
  logic [1087:0] core_in;
  logic          core_in_valid;
  logic          core_more;
  logic          core_hash_next;
  logic [255:0]  core_out;
  logic          core_out_valid;
  logic [255:0]  digest;
  logic          digest_valid;
  logic          digest_ready;

  modport slave (
    input  s_data, s_valid, s_last, s_bytes, core_hash_next, core_out, core_out_valid, digest_ready,
    output s_ready, core_in, core_in_valid, core_more, digest, digest_valid
  );

  modport master (
    output s_data, s_valid, s_last, s_bytes, core_hash_next, core_out, core_out_valid, digest_ready,
    input  s_ready, core_in, core_in_valid, core_more, digest, digest_valid
  );
endinterface

// File: rtl/sha3_block_sequencer.sv
// Packs 64-bit message words into 136-byte SHA3-256 rate blocks, applies 0x06..0x80
// padding and sequences the blocks into a SHA3 core, then holds the returned digest.
module sha3_block_sequencer (
  input logic                   clk,
  input logic                   rst_n,
  sha3_block_sequencer_if.slave bus
);
  localparam int unsigned WordW  = 64;
  localparam int unsigned NWords = 17;
  localparam int unsigned RateW  = WordW * NWords;
  localparam int unsigned CntW   = 5;

  typedef enum logic [2:0] {FILL, ISSUE, WAIT_NEXT, WAIT_OUT, DONE} state_t;

  state_t           state;
  logic [WordW-1:0] blk [NWords];
  logic [CntW-1:0]  cnt;
  logic             pad_pending;

  logic [3:0]       nb;
  logic [WordW-1:0] cur_word;
  logic [WordW-1:0] next_word;
  logic [CntW-1:0]  cnt_inc;
  logic             accept;
  logic             last_full;

  // Word to store this cycle: padded/masked when it is the final word
  always_comb begin
    nb       = (bus.s_bytes > 4'd8) ? 4'd8 : bus.s_bytes;
    cur_word = bus.s_data;
    if (bus.s_last) begin
      for (int j = 0; j < 8; j++) begin
        if (4'(j) >= nb) cur_word[63-8*j -: 8] = 8'h00;
        if (4'(j) == nb) cur_word[63-8*j -: 8] = 8'h06;
      end
      if (cnt == 5'd16 && nb != 4'd8) cur_word[7:0] = cur_word[7:0] | 8'h80;
    end
    // A full final word pushes the 0x06 byte into the following word
    next_word = {8'h06, 56'h0};
    if (cnt == 5'd15) next_word[7:0] = 8'h80;
    cnt_inc   = cnt + 5'd1;
    accept    = bus.s_valid && bus.s_ready;
    last_full = (cnt == 5'd16) && (nb == 4'd8);
  end

  // The buffer is only visible to the core during the strobe cycle
  always_comb begin
    bus.core_in = '0;
    if (bus.core_in_valid) begin
      for (int k = 0; k < NWords; k++) bus.core_in[RateW-1-WordW*k -: WordW] = blk[k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= FILL;
      cnt               <= '0;
      pad_pending       <= 1'b0;
      for (int k = 0; k < NWords; k++) blk[k] <= '0;
      bus.s_ready       <= 1'b0;
      bus.core_in_valid <= 1'b0;
      bus.core_more     <= 1'b0;
      bus.digest_valid  <= 1'b0;
      bus.digest        <= '0;
    end else begin
      bus.core_in_valid <= 1'b0;
      case (state)
        FILL: begin
          bus.s_ready <= 1'b1;
          if (accept) begin
            blk[cnt] <= cur_word;
            if (bus.s_last) begin
              bus.s_ready       <= 1'b0;
              bus.core_in_valid <= 1'b1;
              state             <= ISSUE;
              if (last_full) begin
                pad_pending   <= 1'b1;
                bus.core_more <= 1'b1;
              end else begin
                bus.core_more <= 1'b0;
                if (cnt != 5'd16) blk[16] <= 64'h80;
                if (nb == 4'd8) blk[cnt_inc] <= next_word;
              end
            end else if (cnt == 5'd16) begin
              bus.s_ready       <= 1'b0;
              bus.core_in_valid <= 1'b1;
              bus.core_more     <= 1'b1;
              state             <= ISSUE;
            end else begin
              cnt <= cnt_inc;
            end
          end
        end
        ISSUE: begin
          for (int k = 0; k < NWords; k++) blk[k] <= '0;
          cnt   <= '0;
          state <= bus.core_more ? WAIT_NEXT : WAIT_OUT;
        end
        WAIT_NEXT: begin
          if (bus.core_hash_next) begin
            if (pad_pending) begin
              blk[0]            <= {8'h06, 56'h0};
              blk[16]           <= 64'h80;
              pad_pending       <= 1'b0;
              bus.core_more     <= 1'b0;
              bus.core_in_valid <= 1'b1;
              state             <= ISSUE;
            end else begin
              bus.s_ready <= 1'b1;
              state       <= FILL;
            end
          end
        end
        WAIT_OUT: begin
          if (bus.core_out_valid) begin
            bus.digest       <= bus.core_out;
            bus.digest_valid <= 1'b1;
            state            <= DONE;
          end
        end
        DONE: begin
          if (bus.digest_ready) begin
            bus.digest_valid <= 1'b0;
            bus.s_ready      <= 1'b1;
            state            <= FILL;
          end
        end
        default: state <= FILL;
      endcase
    end
  end
endmodule

// File: tb/tb_sha3_block_sequencer.sv
// Scoreboard bench: stimulus queues expected blocks/digests, independent monitors pop and compare.
module tb_sha3_block_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sha3_block_sequencer_if bus();
  sha3_block_sequencer dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct packed { logic [1087:0] blk; logic more; } exp_t;
  exp_t           exp_q[$];
  logic [255:0]   exp_dig_q[$];
  logic [255:0]   core_dig_q[$];
  int             n_tests = 0;
  int             n_fail = 0;
  int             next_delay = 2;
  int             ready_hold = 1;
  bit             hold_next = 1'b0;
  int             dig_done = 0;
  logic [1087:0]  last_blk = '0;

  task automatic check(string name, logic [255:0] act, logic [255:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic check_blk(string name, logic [1087:0] act, logic [1087:0] req);
    int k;
    k = 0;
    n_tests++;
    if (act !== req) begin
      for (int i = 135; i >= 0; i--) if (act[1087-8*i -: 8] !== req[1087-8*i -: 8]) k = i;
      n_fail++;
      $display("FAIL %s: byte %0d got %h, required %h", name, k, act[1087-8*k -: 8], req[1087-8*k -: 8]);
    end
  endtask

  task automatic spot(string name, int idx, logic [7:0] req);
    check(name, 256'(last_blk[1087-8*idx -: 8]), 256'(req));
  endtask

  function automatic logic [7:0] msg_byte(int n, int seed);
    return 8'(n * 13 + seed * 7 + 1);
  endfunction

  // Reference SHA3 padding over the whole message, sliced into 136-byte blocks
  function automatic logic [1087:0] model_blk(int len, int seed, int b);
    int nblk;
    int pos;
    logic [7:0] v;
    logic [1087:0] r;
    nblk = len / 136 + 1;
    r = '0;
    for (int i = 0; i < 136; i++) begin
      pos = b * 136 + i;
      v = (pos < len) ? msg_byte(pos, seed) : 8'h00;
      if (pos == len) v = v | 8'h06;
      if (i == 135 && b == nblk - 1) v = v | 8'h80;
      r[1087-8*i -: 8] = v;
    end
    return r;
  endfunction

  task automatic send(int len, int seed, int nsend, bit ovr, logic [3:0] ovr_val);
    int nw;
    int cyc;
    logic [63:0] d;
    nw = (len == 0) ? 1 : (len + 7) / 8;
    for (int w = 0; w < nw && w < nsend; w++) begin
      for (int j = 0; j < 8; j++) d[63-8*j -: 8] = (8*w + j < len) ? msg_byte(8*w + j, seed) : 8'hEE;
      bus.s_data  = d;
      bus.s_last  = (w == nw - 1);
      bus.s_bytes = (w != nw - 1) ? 4'h5 : (ovr ? ovr_val : 4'(len - 8*w));
      bus.s_valid = 1'b1;
      cyc = 0;
      while (!bus.s_ready && cyc < 3000) begin
        @(negedge clk);
        cyc++;
      end
      if (!bus.s_ready) begin
        n_tests++;
        n_fail++;
        $display("FAIL s_ready_timeout: got 0 after %0d cycles, required 1", cyc);
        bus.s_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
  endtask

  task automatic wait_done(int target);
    int c;
    c = 0;
    while (dig_done < target && c < 5000) begin
      @(negedge clk);
      c++;
    end
    if (dig_done < target) begin
      n_tests++;
      n_fail++;
      $display("FAIL digest_timeout: got %0d digests, required %0d", dig_done, target);
    end
  endtask

  task automatic run_msg(int len, int seed, logic [255:0] dig, bit ovr, logic [3:0] ovr_val);
    int nblk;
    int target;
    nblk = len / 136 + 1;
    for (int b = 0; b < nblk; b++) exp_q.push_back('{model_blk(len, seed, b), (b < nblk - 1)});
    exp_dig_q.push_back(dig);
    core_dig_q.push_back(dig);
    target = dig_done + 1;
    send(len, seed, 1000, ovr, ovr_val);
    wait_done(target);
  endtask

  // Block monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (bus.core_in_valid) begin
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_strobe: got core_in_valid=1, required 0");
          end else begin
            e = exp_q.pop_front();
            check_blk("block", bus.core_in, e.blk);
            check("core_more", 256'(bus.core_more), 256'(e.more));
            last_blk = bus.core_in;
          end
        end else begin
          check_blk("core_in_idle", bus.core_in, '0);
        end
      end
    end
  end

  // Core model: acknowledges intermediate blocks, returns a digest after the final block
  initial begin
    bit stall_ok;
    logic [255:0] d;
    bus.core_hash_next = 1'b0;
    bus.core_out_valid = 1'b0;
    bus.core_out       = '0;
    forever begin
      @(negedge clk);
      if (rst_n && bus.core_in_valid) begin
        if (bus.core_more) begin
          if (!hold_next) begin
            stall_ok = 1'b1;
            for (int i = 0; i < next_delay; i++) begin
              @(negedge clk);
              if (bus.s_ready !== 1'b0) stall_ok = 1'b0;
            end
            check("s_ready_low_in_wait", 256'(stall_ok), 256'(1'b1));
            bus.core_hash_next = 1'b1;
            @(posedge clk);
            #1 bus.core_hash_next = 1'b0;
          end
        end else begin
          repeat (2) @(negedge clk);
          d = (core_dig_q.size() != 0) ? core_dig_q.pop_front() : '0;
          bus.core_out       = d;
          bus.core_out_valid = 1'b1;
          @(negedge clk);
          bus.core_out = ~d;
          @(negedge clk);
          bus.core_out_valid = 1'b0;
        end
      end
    end
  end

  // Digest consumer: holds digest_ready low for ready_hold cycles, checking stability
  initial begin
    bit ok;
    logic [255:0] cap;
    bus.digest_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && bus.digest_valid) begin
        if (exp_dig_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_digest: got digest_valid=1, required 0");
        end else begin
          check("digest", bus.digest, exp_dig_q.pop_front());
        end
        cap = bus.digest;
        ok = 1'b1;
        repeat (ready_hold) begin
          @(negedge clk);
          if (!(bus.digest_valid === 1'b1 && bus.digest === cap)) ok = 1'b0;
        end
        check("digest_hold", 256'(ok), 256'(1'b1));
        bus.digest_ready = 1'b1;
        @(negedge clk);
        bus.digest_ready = 1'b0;
        check("digest_valid_drop", 256'(bus.digest_valid), 256'(1'b0));
        dig_done++;
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.s_last  = 1'b0;
    bus.s_bytes = '0;
    repeat (3) @(negedge clk);
    check("rst_core_in_valid", 256'(bus.core_in_valid), 256'(1'b0));
    check("rst_core_more", 256'(bus.core_more), 256'(1'b0));
    check("rst_digest_valid", 256'(bus.digest_valid), 256'(1'b0));
    check("rst_digest", bus.digest, '0);
    check_blk("rst_core_in", bus.core_in, '0);
    rst_n = 1'b1;
    @(posedge clk);
    #1 check("s_ready_after_reset", 256'(bus.s_ready), 256'(1'b1));

    run_msg(0, 1, {16{16'hA7FF}}, 1'b0, 4'h0);
    spot("empty_b0", 0, 8'h06);
    spot("empty_b1", 1, 8'h00);
    spot("empty_b135", 135, 8'h80);

    run_msg(19, 2, {8{32'hC0DE_0002}}, 1'b0, 4'h0);
    spot("m19_b19", 19, 8'h06);
    spot("m19_b20", 20, 8'h00);
    spot("m19_b135", 135, 8'h80);

    run_msg(135, 3, {8{32'hC0DE_0003}}, 1'b0, 4'h0);
    spot("m135_b134", 134, 8'hE4);
    spot("m135_b135", 135, 8'h86);

    run_msg(136, 4, {8{32'hC0DE_0004}}, 1'b0, 4'h0);
    spot("m136_pad_b0", 0, 8'h06);
    spot("m136_pad_b135", 135, 8'h80);

    next_delay = 48;
    ready_hold = 5;
    run_msg(200, 5, {8{32'hC0DE_0005}}, 1'b0, 4'h0);
    spot("m200_b64", 64, 8'h06);
    next_delay = 2;
    ready_hold = 1;

    run_msg(128, 6, {8{32'hC0DE_0006}}, 1'b0, 4'h0);
    spot("m128_b128", 128, 8'h06);
    spot("m128_b135", 135, 8'h80);

    run_msg(24, 7, {8{32'hC0DE_0007}}, 1'b1, 4'hF);
    spot("m24_clamp_b24", 24, 8'h06);

    // Abandon a message while the core holds off core_hash_next
    hold_next = 1'b1;
    exp_q.push_back('{model_blk(200, 8, 0), 1'b1});
    send(200, 8, 17, 1'b0, 4'h0);
    c = 0;
    while (exp_q.size() != 0 && c < 100) begin
      @(negedge clk);
      c++;
    end
    check("abort_first_block_seen", 256'(exp_q.size()), 256'(0));
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #2;
    check("abort_core_in_valid", 256'(bus.core_in_valid), 256'(1'b0));
    check("abort_core_more", 256'(bus.core_more), 256'(1'b0));
    check("abort_digest_valid", 256'(bus.digest_valid), 256'(1'b0));
    check("abort_digest", bus.digest, '0);
    check_blk("abort_core_in", bus.core_in, '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    hold_next = 1'b0;
    run_msg(10, 9, {8{32'hC0DE_0009}}, 1'b0, 4'h0);
    spot("m10_b10", 10, 8'h06);
    spot("m10_b135", 135, 8'h80);

    repeat (20) @(negedge clk);
    check("blocks_left", 256'(exp_q.size()), 256'(0));
    check("digests_left", 256'(exp_dig_q.size()), 256'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
